// File: rtl/cmd_reply_packer.sv
// cmd_reply_packer: collects 16-bit command-engine reply words into a payload
// buffer and emits fixed-size in-band reply packets (2-word header, payload,
// zero padding) on the control channel toward the RX packet FIFO.
module cmd_reply_packer #(
  parameter int         PKT_WORDS  = 256,
  parameter int         FLUSH_IDLE = 16,
  parameter logic [4:0] CHANNEL    = 5'h1f
) (
  input  logic        txclk,
  input  logic        reset,
  input  logic [31:0] timestamp_clock,
  input  logic        rx_WR,
  input  logic [15:0] rx_databus,
  input  logic        rx_WR_done,
  input  logic [3:0]  tx_tag,
  output logic        rx_WR_enabled,
  input  logic        pkt_space,
  output logic        pkt_wr,
  output logic [15:0] pkt_data,
  output logic        pkt_done,
  output logic        reply_overflow
);

  localparam int BUF_WORDS = PKT_WORDS - 4;
  localparam int FW        = $clog2(BUF_WORDS + 1);
  localparam int AW        = $clog2(BUF_WORDS);
  localparam int CW        = $clog2(PKT_WORDS);
  localparam int IW        = $clog2(FLUSH_IDLE + 1);

  // Accept while at least two slots remain; the registered enable lags fill by
  // one cycle, so a back-to-back writer can land one more word in the last slot.
  localparam logic [FW-1:0] EN_MAX    = FW'(PKT_WORDS - 6);
  localparam logic [FW-1:0] FULL_LVL  = FW'(PKT_WORDS - 5);
  localparam logic [IW-1:0] IDLE_LAST = IW'(FLUSH_IDLE - 1);
  localparam logic [CW-1:0] LAST_W    = CW'(PKT_WORDS - 1);

  typedef enum logic [2:0] {
    ST_ACCUM,
    ST_WAIT_SPACE,
    ST_HDR,
    ST_PAYLOAD,
    ST_PAD
  } state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [IW-1:0]     idle_cnt_q, idle_cnt_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              en_q, en_d;
  logic              ovf_q, ovf_d;
  logic [3:0]        tag_q, tag_d;
  logic [31:0]       ts_q, ts_d;

  logic [15:0]       mem [BUF_WORDS];
  logic [15:0]       rd_data_p1;
  logic [AW-1:0]     rd_addr;

  logic              store;
  logic              idle;
  logic              flush;
  logic              emitting;
  logic [CW-1:0]     pay_last;
  logic [31:0]       hdr_w0;

  assign store    = (state_q == ST_ACCUM) && rx_WR && en_q;
  assign idle     = rx_WR_done && !rx_WR && (fill_q != '0);
  assign flush    = (state_q == ST_ACCUM) &&
                    ((idle && (idle_cnt_q == IDLE_LAST)) || (fill_q >= FULL_LVL));
  assign emitting = (state_q == ST_HDR) || (state_q == ST_PAYLOAD) || (state_q == ST_PAD);
  assign pay_last = CW'(fill_q) + CW'(3);

  // Output word index n reads buffer slot n-4; issuing the read one word early
  // hides the RAM latency so the payload streams without gaps.
  assign rd_addr  = AW'(wcnt_q - CW'(3));

  assign hdr_w0   = {3'b000, 1'b1, 1'b1, 6'b000000, CHANNEL, 3'b000, tag_q,
                     9'({fill_q, 1'b0})};

  // Control state register: async reset returns to an empty accumulator.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ACCUM;
      fill_q     <= '0;
      idle_cnt_q <= '0;
      wcnt_q     <= '0;
      en_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      idle_cnt_q <= idle_cnt_d;
      wcnt_q     <= wcnt_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
    end
  end

  // Header data registers: only meaningful once a packet is being built.
  always_ff @(posedge txclk) begin
    tag_q <= tag_d;
    ts_q  <= ts_d;
  end

  // Payload buffer write port: slot index is the current fill level.
  always_ff @(posedge txclk) begin
    if (store) mem[AW'(fill_q)] <= rx_databus;
  end

  // Stage p1: registered buffer read feeding the payload output mux.
  always_ff @(posedge txclk) begin
    rd_data_p1 <= mem[rd_addr];
  end

  // Next-state logic: accumulate, wait for FIFO room, then stream one packet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM:      if (flush) state_d = ST_WAIT_SPACE;
      ST_WAIT_SPACE: if (pkt_space) state_d = ST_HDR;
      ST_HDR:        if (wcnt_q == CW'(3)) state_d = ST_PAYLOAD;
      ST_PAYLOAD: begin
        if (wcnt_q == LAST_W)        state_d = ST_ACCUM;
        else if (wcnt_q == pay_last) state_d = ST_PAD;
      end
      ST_PAD:        if (wcnt_q == LAST_W) state_d = ST_ACCUM;
      default:       state_d = ST_ACCUM;
    endcase
  end

  // Counters, flow control and header capture for the next cycle.
  always_comb begin
    fill_d     = fill_q;
    idle_cnt_d = '0;
    wcnt_d     = '0;
    tag_d      = tag_q;
    ts_d       = ts_q;
    ovf_d      = rx_WR && !en_q;
    en_d       = (state_d == ST_ACCUM) && (fill_q <= EN_MAX);
    if (store) begin
      fill_d = fill_q + FW'(1);
      if (fill_q == '0) tag_d = tx_tag;
    end
    if ((state_q == ST_ACCUM) && idle)
      idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + IW'(1);
    if ((state_q == ST_ACCUM) && (state_d == ST_WAIT_SPACE))
      ts_d = timestamp_clock;
    if (emitting) wcnt_d = wcnt_q + CW'(1);
    if (emitting && (state_d == ST_ACCUM)) fill_d = '0;
  end

  // Output decode: header halves, buffered payload, then zero padding.
  always_comb begin
    pkt_wr         = emitting;
    pkt_done       = emitting && (wcnt_q == LAST_W);
    pkt_data       = '0;
    rx_WR_enabled  = en_q;
    reply_overflow = ovf_q;
    case (state_q)
      ST_HDR: begin
        case (wcnt_q[1:0])
          2'd0:    pkt_data = hdr_w0[15:0];
          2'd1:    pkt_data = hdr_w0[31:16];
          2'd2:    pkt_data = ts_q[15:0];
          default: pkt_data = ts_q[31:16];
        endcase
      end
      ST_PAYLOAD: pkt_data = rd_data_p1;
      default:    pkt_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cmd_reply_packer.sv
// Bench for cmd_reply_packer: scoreboard of expected packet words, filled as
// replies are driven and drained by a negedge monitor on pkt_wr.
module tb_cmd_reply_packer;

  localparam int PKT_WORDS = 256;

  typedef struct packed {
    logic [15:0] data;
    logic        done;
  } exp_t;

  logic        txclk = 1'b0;
  logic        reset;
  logic [31:0] timestamp_clock;
  logic        rx_WR;
  logic [15:0] rx_databus;
  logic        rx_WR_done;
  logic [3:0]  tx_tag;
  logic        rx_WR_enabled;
  logic        pkt_space;
  logic        pkt_wr;
  logic [15:0] pkt_data;
  logic        pkt_done;
  logic        reply_overflow;

  exp_t        exp_q[$];
  logic [15:0] pl_q[$];
  logic [3:0]  pkt_tag;
  logic [31:0] exp_ts;
  int          n_cmp = 0;
  int          n_err = 0;
  int          ovf_cnt = 0;
  int          ovf_base;
  bit          in_pkt = 1'b0;

  cmd_reply_packer dut (
    .txclk          (txclk),
    .reset          (reset),
    .timestamp_clock(timestamp_clock),
    .rx_WR          (rx_WR),
    .rx_databus     (rx_databus),
    .rx_WR_done     (rx_WR_done),
    .tx_tag         (tx_tag),
    .rx_WR_enabled  (rx_WR_enabled),
    .pkt_space      (pkt_space),
    .pkt_wr         (pkt_wr),
    .pkt_data       (pkt_data),
    .pkt_done       (pkt_done),
    .reply_overflow (reply_overflow)
  );

  always #5 txclk = ~txclk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // One clock; inputs change 1 time unit after the edge, timestamp advances.
  task automatic tick();
    @(posedge txclk);
    #1;
    timestamp_clock = timestamp_clock + 32'h0001_0003;
  endtask

  task automatic put_word(input logic [15:0] w, input bit acc);
    if (acc) begin
      if (pl_q.size() == 0) pkt_tag = tx_tag;
      pl_q.push_back(w);
    end
    rx_WR      = 1'b1;
    rx_databus = w;
    tick();
    rx_WR      = 1'b0;
  endtask

  // Hold done high: still accumulating after 15 idle cycles, flushed on the 16th.
  task automatic done_flush();
    rx_WR_done = 1'b1;
    repeat (15) tick();
    check_eq("no_early_flush", 32'(rx_WR_enabled), 32'd1);
    exp_ts = timestamp_clock;
    tick();
    check_eq("flush_en_low", 32'(rx_WR_enabled), 32'd0);
  endtask

  task automatic push_pkt(input logic [31:0] ts);
    logic [31:0] w0;
    exp_t        e;
    int          n;
    n  = pl_q.size();
    w0 = {3'b000, 1'b1, 1'b1, 6'b000000, 5'h1f, 3'b000, pkt_tag, 9'(2 * n)};
    for (int k = 0; k < PKT_WORDS; k++) begin
      if (k == 0)          e.data = w0[15:0];
      else if (k == 1)     e.data = w0[31:16];
      else if (k == 2)     e.data = ts[15:0];
      else if (k == 3)     e.data = ts[31:16];
      else if (k < 4 + n)  e.data = pl_q[k - 4];
      else                 e.data = 16'h0000;
      e.done = (k == PKT_WORDS - 1);
      exp_q.push_back(e);
    end
    pl_q.delete();
  endtask

  task automatic wait_drain();
    int budget = 400;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_en();
    int budget = 10;
    while (!rx_WR_enabled && budget > 0) begin
      tick();
      budget--;
    end
    check_eq("en_back", 32'(rx_WR_enabled), 32'd1);
  endtask

  // Monitor: pop one expected word per pkt_wr, packet must be gap-free.
  always @(negedge txclk) begin
    if (reset) begin
      in_pkt = 1'b0;
    end else begin
      if (reply_overflow) ovf_cnt++;
      if (in_pkt) check_eq("contig", 32'(pkt_wr), 32'd1);
      if (pkt_wr) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_wr", 32'(pkt_wr), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("pkt_data", 32'(pkt_data), 32'(e.data));
          check_eq("pkt_done", 32'(pkt_done), 32'(e.done));
          in_pkt = !e.done;
        end
      end else if (pkt_done) begin
        check_eq("done_no_wr", 32'(pkt_done), 32'd0);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    timestamp_clock = 32'h1000_0000;
    rx_WR           = 1'b0;
    rx_databus      = '0;
    rx_WR_done      = 1'b0;
    tx_tag          = '0;
    pkt_space       = 1'b1;

    // Reset state
    repeat (2) @(posedge txclk);
    #1;
    check_eq("rst_pkt_wr",   32'(pkt_wr),         32'd0);
    check_eq("rst_pkt_done", 32'(pkt_done),       32'd0);
    check_eq("rst_pkt_data", 32'(pkt_data),       32'd0);
    check_eq("rst_en",       32'(rx_WR_enabled),  32'd0);
    check_eq("rst_ovf",      32'(reply_overflow), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check_eq("en_after_rst", 32'(rx_WR_enabled), 32'd1);

    // Ping reply: tag 3, two words
    tx_tag = 4'd3;
    put_word(16'h1234, 1'b1);
    put_word(16'h0102, 1'b1);
    check_eq("ping_hdr0_model", 32'({3'b000, 1'b1, 1'b1, 6'd0, 5'h1f, 3'd0, pkt_tag, 9'd4}),
             32'h181F_0604);
    done_flush();
    push_pkt(exp_ts);
    wait_drain();
    check_eq("ping_no_ovf", 32'(ovf_cnt), 32'd0);
    rx_WR_done = 1'b0;
    wait_en();

    // Read-reg reply: four words, a short done pulse that must not flush
    tx_tag = 4'hA;
    put_word(16'hAAA1, 1'b1);
    tick();
    put_word(16'hAAA2, 1'b1);
    rx_WR_done = 1'b1;
    repeat (10) tick();
    check_eq("short_idle_en", 32'(rx_WR_enabled), 32'd1);
    rx_WR_done = 1'b0;
    put_word(16'hAAA3, 1'b1);
    tick();
    put_word(16'hAAA4, 1'b1);
    done_flush();
    push_pkt(exp_ts);
    wait_drain();
    rx_WR_done = 1'b0;
    wait_en();

    // Back-to-back fill: 252 words land, the rest overflow
    ovf_base = ovf_cnt;
    for (int i = 0; i < 260; i++) begin
      tx_tag = (i == 0) ? 4'd5 : 4'd9;
      if (i == 251) exp_ts = timestamp_clock;
      put_word(16'hC000 + 16'(i), i < 252);
      if (i == 250) check_eq("en_at_fill251", 32'(rx_WR_enabled), 32'd1);
      if (i == 251) begin
        check_eq("full_en_low", 32'(rx_WR_enabled), 32'd0);
        push_pkt(exp_ts);
      end
    end
    tick();
    check_eq("full_ovf", 32'(ovf_cnt - ovf_base), 32'd8);
    wait_drain();
    wait_en();

    // No FIFO space for 100 cycles after the flush trigger
    pkt_space = 1'b0;
    tx_tag    = 4'hC;
    put_word(16'h5A01, 1'b1);
    put_word(16'h5A02, 1'b1);
    put_word(16'h5A03, 1'b1);
    done_flush();
    ovf_base = ovf_cnt;
    for (int i = 0; i < 100; i++) begin
      if (i == 10 || i == 50) put_word(16'hDEAD, 1'b0);
      else tick();
    end
    check_eq("hold_en_low", 32'(rx_WR_enabled), 32'd0);
    check_eq("hold_ovf",    32'(ovf_cnt - ovf_base), 32'd2);
    check_eq("hold_no_wr",  32'(pkt_wr), 32'd0);
    push_pkt(exp_ts);
    pkt_space = 1'b1;
    tick();
    check_eq("space_start", 32'(pkt_wr), 32'd1);
    repeat (3) tick();
    pkt_space = 1'b0;
    wait_drain();
    pkt_space  = 1'b1;
    rx_WR_done = 1'b0;
    wait_en();

    // Reset while streaming payload
    tx_tag = 4'd2;
    put_word(16'h1111, 1'b1);
    put_word(16'h2222, 1'b1);
    put_word(16'h3333, 1'b1);
    done_flush();
    push_pkt(exp_ts);
    repeat (6) tick();
    check_eq("pre_rst_wr", 32'(pkt_wr), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_eq("rst_mid_wr",   32'(pkt_wr),   32'd0);
    check_eq("rst_mid_done", 32'(pkt_done), 32'd0);
    rx_WR_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    wait_en();
    tx_tag = 4'd7;
    put_word(16'hBEEF, 1'b1);
    done_flush();
    push_pkt(exp_ts);
    wait_drain();
    rx_WR_done = 1'b0;
    wait_en();

    // Long done with an empty buffer never produces a packet
    rx_WR_done = 1'b1;
    repeat (1000) tick();
    check_eq("empty_idle_en", 32'(rx_WR_enabled), 32'd1);
    check_eq("empty_idle_wr", 32'(pkt_wr), 32'd0);
    rx_WR_done = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
